// File: rtl/alu_seq.sv
// Flag-keeping ALU with carry-chained arithmetic, logic and shift ops, plus a multi-cycle
// shift-add multiplier behind a valid/ready handshake. Results and flags are registered.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             c_flag,
    output logic             z_flag,
    output logic             n_flag
);

    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OpMv  = OPW'(0);
    localparam logic [OPW-1:0] OpAdd = OPW'(1);
    localparam logic [OPW-1:0] OpAdc = OPW'(2);
    localparam logic [OPW-1:0] OpSub = OPW'(3);
    localparam logic [OPW-1:0] OpAnd = OPW'(4);
    localparam logic [OPW-1:0] OpOr  = OPW'(5);
    localparam logic [OPW-1:0] OpXor = OPW'(6);
    localparam logic [OPW-1:0] OpShl = OPW'(7);
    localparam logic [OPW-1:0] OpShr = OPW'(8);
    localparam logic [OPW-1:0] OpMul = OPW'(9);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               c_q, c_d;
    logic               z_q, z_d;
    logic               n_q, n_d;
    logic               out_valid_q, out_valid_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               accept;
    logic [SW-1:0]      shamt;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c;
    logic               alu_upd_c;
    logic               alu_upd_zn;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign in_ready  = (state_q == StIdle);
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign n_flag    = n_q;

    // The extra bit on each shifter catches the last bit shifted out.
    assign shamt = in2[SW-1:0];
    assign shl_w = {1'b0, in1} << shamt;
    assign shr_w = {in1, 1'b0} >> shamt;

    always_comb begin
        alu_r      = '0;
        alu_c      = c_q;
        alu_upd_c  = 1'b0;
        alu_upd_zn = 1'b0;
        sum_w      = '0;
        case (op)
            OpMv: begin
                alu_r = in1;
            end
            OpAdd: begin
                sum_w      = {1'b0, in1} + {1'b0, in2};
                alu_r      = sum_w[WIDTH-1:0];
                alu_c      = sum_w[WIDTH];
                alu_upd_c  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OpAdc: begin
                sum_w      = {1'b0, in1} + {1'b0, in2} + (WIDTH+1)'(c_q);
                alu_r      = sum_w[WIDTH-1:0];
                alu_c      = sum_w[WIDTH];
                alu_upd_c  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OpSub: begin
                // The top bit of the widened difference is the borrow.
                sum_w      = {1'b0, in1} - {1'b0, in2};
                alu_r      = sum_w[WIDTH-1:0];
                alu_c      = sum_w[WIDTH];
                alu_upd_c  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            OpAnd: begin
                alu_r      = in1 & in2;
                alu_upd_zn = 1'b1;
            end
            OpOr: begin
                alu_r      = in1 | in2;
                alu_upd_zn = 1'b1;
            end
            OpXor: begin
                alu_r      = in1 ^ in2;
                alu_upd_zn = 1'b1;
            end
            OpShl: begin
                alu_r      = shl_w[WIDTH-1:0];
                alu_c      = shl_w[WIDTH];
                alu_upd_c  = (shamt != '0);
                alu_upd_zn = 1'b1;
            end
            OpShr: begin
                alu_r      = shr_w[WIDTH:1];
                alu_c      = shr_w[0];
                alu_upd_c  = (shamt != '0);
                alu_upd_zn = 1'b1;
            end
            default: begin
                alu_r = '0;
            end
        endcase
    end

    // One shift-add step: add the multiplicand into the high half when the LSB is set, shift right.
    assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                               : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMul) begin
                        mcand_d = in1;
                        acc_d   = {{WIDTH{1'b0}}, in2};
                        cnt_d   = SW'(WIDTH - 1);
                        state_d = StMul;
                    end else begin
                        out_d       = alu_r;
                        out_valid_d = 1'b1;
                        if (alu_upd_c) begin
                            c_d = alu_c;
                        end
                        if (alu_upd_zn) begin
                            z_d = (alu_r == '0);
                            n_d = alu_r[WIDTH-1];
                        end
                    end
                end
            end
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) begin
                    state_d     = StIdle;
                    out_d       = mul_next[WIDTH-1:0];
                    c_d         = (mul_next[2*WIDTH-1:WIDTH] != '0);
                    z_d         = (mul_next[WIDTH-1:0] == '0);
                    n_d         = mul_next[WIDTH-1];
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            out_q       <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table with hand-computed results plus hand-written
// sequences for back-to-back issue, stalls during multiply and reset.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        out_valid;
    logic [15:0] out;
    logic        c_flag;
    logic        z_flag;
    logic        n_flag;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        c;
        logic        z;
        logic        n;
        logic [5:0]  lat;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    alu_seq #(
        .WIDTH(16),
        .OPW  (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out      (out),
        .c_flag   (c_flag),
        .z_flag   (z_flag),
        .n_flag   (n_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_rst_state(input string tag);
        check({tag, " out"}, 32'(out), 32'h0);
        check({tag, " flags"}, {29'd0, c_flag, z_flag, n_flag}, 32'h0);
        check({tag, " in_ready"}, 32'(in_ready), 32'h1);
        check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  cyc;
        int  low;
        bit  seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, " ready"}, 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        op       = v.op;
        in1      = v.a;
        in2      = v.b;
        cyc      = 0;
        low      = 0;
        seen     = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            // Scramble operands after accept; a multiply must have captured them already.
            in_valid = 1'b0;
            in1      = 16'hDEAD;
            in2      = 16'hBEEF;
            cyc++;
            if (out_valid) seen = 1'b1;
            else if (!in_ready) low++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(v.lat));
        check({tag, " ready_low"}, 32'(low), (v.op == 7'd9) ? 32'd16 : 32'd0);
        check({tag, " out"}, 32'(out), 32'(v.r));
        check({tag, " cflag"}, 32'(c_flag), 32'(v.c));
        check({tag, " zflag"}, 32'(z_flag), 32'(v.z));
        check({tag, " nflag"}, 32'(n_flag), 32'(v.n));
    endtask

    initial begin
        int  cyc;
        int  pulses;
        //          op     a         b         r         c     z     n     lat
        vecs[0]  = '{7'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[1]  = '{7'd2, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[2]  = '{7'd3, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1, 6'd1};
        vecs[3]  = '{7'd4, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[4]  = '{7'd5, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b1, 1'b0, 1'b0, 6'd1};
        vecs[5]  = '{7'd6, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b1, 6'd1};
        vecs[6]  = '{7'd7, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 6'd1};
        vecs[7]  = '{7'd1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[8]  = '{7'd8, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[9]  = '{7'd3, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 6'd1};
        vecs[10] = '{7'd7, 16'h4321, 16'h0000, 16'h4321, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[11] = '{7'd8, 16'h4000, 16'h000F, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[12] = '{7'd7, 16'h0003, 16'h000F, 16'h8000, 1'b1, 1'b0, 1'b1, 6'd1};
        vecs[13] = '{7'd7, 16'h0001, 16'h0010, 16'h0001, 1'b1, 1'b0, 1'b0, 6'd1};
        vecs[14] = '{7'd0, 16'h1234, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 6'd1};
        vecs[15] = '{7'h7F, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, 1'b0, 6'd1};
        vecs[16] = '{7'd3, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 6'd1};
        vecs[17] = '{7'd0, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 6'd1};
        vecs[18] = '{7'd2, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[19] = '{7'd9, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd17};
        vecs[20] = '{7'd9, 16'h0007, 16'h0006, 16'h002A, 1'b0, 1'b0, 1'b0, 6'd17};
        vecs[21] = '{7'd9, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 6'd17};
        vecs[22] = '{7'd2, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[23] = '{7'd2, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 6'd1};
        vecs[24] = '{7'd2, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[25] = '{7'd2, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[26] = '{7'h0A, 16'h5555, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[27] = '{7'd9, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 6'd17};

        rst      = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        in1      = '0;
        in2      = '0;
        #1 rst = 1'b1;
        #1 check_rst_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back ADD then ADC: the ADC must see the carry the ADD just registered.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 7'd1;
        in1      = 16'hFFFF;
        in2      = 16'h0001;
        @(posedge clk);
        #1;
        check("b2b add out", 32'(out), 32'h0000);
        check("b2b add flags", {29'd0, c_flag, z_flag, n_flag}, 32'b110);
        check("b2b add valid", 32'(out_valid), 32'h1);
        op  = 7'd2;
        in1 = 16'h0001;
        in2 = 16'h0001;
        @(posedge clk);
        #1;
        check("b2b adc out", 32'(out), 32'h0003);
        check("b2b adc c", 32'(c_flag), 32'h0);
        check("b2b adc valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b pulse end", 32'(out_valid), 32'h0);
        check("b2b hold out", 32'(out), 32'h0003);

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Request held during a multiply is taken only once in_ready returns.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 7'd9;
        in1      = 16'h0007;
        in2      = 16'h0006;
        @(posedge clk);
        #1;
        op  = 7'd1;
        in1 = 16'h0002;
        in2 = 16'h0003;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hold mul cycles", 32'(cyc), 32'd16);
        check("hold mul out", 32'(out), 32'd42);
        check("hold mul c", 32'(c_flag), 32'h0);
        check("hold ready back", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("hold add valid", 32'(out_valid), 32'h1);
        check("hold add out", 32'(out), 32'd5);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("hold pulse end", 32'(out_valid), 32'h0);

        // Reset mid-multiply aborts it without a completion pulse.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 7'd9;
        in1      = 16'h0003;
        in2      = 16'h0003;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mul busy", 32'(in_ready), 32'h0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_rst_state("midmul reset");
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("aborted mul pulses", 32'(pulses), 32'h0);
        run_vec(100, '{7'd1, 16'h0002, 16'h0002, 16'h0004, 1'b0, 1'b0, 1'b0, 6'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
